// File: rtl/lpc_frame_mover.sv
`default_nettype none
// ============================================================================
// Module   : lpc_frame_mover
// Brief    : Command-driven memory-to-memory copy sequencer that drives the
//            read-master and write-master control/stream conduits.
// Revision : 1.0 - initial release
// ============================================================================
module lpc_frame_mover #(
    parameter int   DATA_WIDTH = 16,
    parameter int   ADDR_WIDTH = 32,
    parameter logic SRC_FIXED  = 1'b0,
    parameter logic DST_FIXED  = 1'b0,
    parameter int   TIMEOUT    = 65535
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cal_success,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_src_base,
    input  logic [ADDR_WIDTH-1:0] cmd_dst_base,
    input  logic [ADDR_WIDTH-1:0] cmd_length,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic                  rm_fixed_location,
    output logic [ADDR_WIDTH-1:0] rm_read_base,
    output logic [ADDR_WIDTH-1:0] rm_read_length,
    output logic                  rm_go,
    input  logic                  rm_done,
    input  logic                  rm_early_done,
    output logic                  rm_read_buffer,
    input  logic [DATA_WIDTH-1:0] rm_buffer_output_data,
    input  logic                  rm_data_available,
    output logic                  wm_fixed_location,
    output logic [ADDR_WIDTH-1:0] wm_write_base,
    output logic [ADDR_WIDTH-1:0] wm_write_length,
    output logic                  wm_go,
    input  logic                  wm_done,
    output logic                  wm_write_buffer,
    output logic [DATA_WIDTH-1:0] wm_buffer_input_data,
    input  logic                  wm_buffer_full
);

    localparam logic [ADDR_WIDTH-1:0] C_BYTES_PER_WORD = ADDR_WIDTH'(DATA_WIDTH / 8);
    localparam logic [15:0]           C_TIMEOUT        = 16'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_MOVE  = 3'd2,
        S_WAIT  = 3'd3,
        S_FIN   = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_src;
    logic [ADDR_WIDTH-1:0] r_dst;
    logic [ADDR_WIDTH-1:0] r_len;
    logic [ADDR_WIDTH-1:0] r_words;
    logic [ADDR_WIDTH-1:0] r_popped;
    logic                  r_pipe_valid;
    logic [DATA_WIDTH-1:0] r_pipe_data;
    logic                  r_rm_flag;
    logic                  r_wm_flag;
    logic [15:0]           r_wdog;

    logic w_active;
    logic w_push;
    logic w_pop;
    logic w_progress;
    logic w_timeout;
    logic w_bad_cmd;
    logic w_unused;

    assign w_active   = (r_state == S_MOVE) || (r_state == S_WAIT);
    assign w_push     = r_pipe_valid & ~wm_buffer_full;
    assign w_pop      = (r_state == S_MOVE) & rm_data_available & (r_popped < r_words)
                        & (~r_pipe_valid | w_push);
    assign w_progress = w_pop | w_push | (rm_done & ~r_rm_flag) | (wm_done & ~r_wm_flag);
    assign w_timeout  = w_active & ~w_progress & ((r_wdog + 16'd1) == C_TIMEOUT);
    assign w_bad_cmd  = (cmd_length == '0) || ((cmd_length % C_BYTES_PER_WORD) != '0)
                        || !cal_success;
    assign w_unused   = rm_early_done;

    assign rm_fixed_location    = SRC_FIXED;
    assign wm_fixed_location    = DST_FIXED;
    assign rm_read_base         = r_src;
    assign rm_read_length       = r_len;
    assign wm_write_base        = r_dst;
    assign wm_write_length      = r_len;
    assign rm_read_buffer       = w_pop;
    assign wm_write_buffer      = w_push;
    assign wm_buffer_input_data = r_pipe_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            cmd_ready    <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            rm_go        <= 1'b0;
            wm_go        <= 1'b0;
            r_src        <= '0;
            r_dst        <= '0;
            r_len        <= '0;
            r_words      <= '0;
            r_popped     <= '0;
            r_pipe_valid <= 1'b0;
            r_pipe_data  <= '0;
            r_rm_flag    <= 1'b0;
            r_wm_flag    <= 1'b0;
            r_wdog       <= '0;
        end else begin
            rm_go <= 1'b0;
            wm_go <= 1'b0;
            done  <= 1'b0;
            error <= 1'b0;

            if (w_pop) begin
                r_pipe_data  <= rm_buffer_output_data;
                r_pipe_valid <= 1'b1;
                r_popped     <= r_popped + ADDR_WIDTH'(1);
            end else if (w_push) begin
                r_pipe_valid <= 1'b0;
            end

            // Done pulses are captured from MOVE onward so a master that
            // finishes before the pipeline drains is not missed.
            if (w_active) begin
                if (rm_done) r_rm_flag <= 1'b1;
                if (wm_done) r_wm_flag <= 1'b1;
                r_wdog <= w_progress ? 16'd0 : r_wdog + 16'd1;
            end

            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_src     <= cmd_src_base;
                        r_dst     <= cmd_dst_base;
                        r_len     <= cmd_length;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (w_bad_cmd) begin
                            r_state <= S_ERR;
                            error   <= 1'b1;
                        end else begin
                            r_state <= S_START;
                            rm_go   <= 1'b1;
                            wm_go   <= 1'b1;
                        end
                    end
                end
                S_START: begin
                    r_words   <= r_len / C_BYTES_PER_WORD;
                    r_popped  <= '0;
                    r_rm_flag <= 1'b0;
                    r_wm_flag <= 1'b0;
                    r_wdog    <= '0;
                    r_state   <= S_MOVE;
                end
                S_MOVE: begin
                    if (w_timeout) begin
                        r_state      <= S_ERR;
                        error        <= 1'b1;
                        r_pipe_valid <= 1'b0;
                    end else if ((r_popped == r_words) && !r_pipe_valid) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (w_timeout) begin
                        r_state      <= S_ERR;
                        error        <= 1'b1;
                        r_pipe_valid <= 1'b0;
                    end else if (r_rm_flag && r_wm_flag) begin
                        r_state <= S_FIN;
                        done    <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
